// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller: state codes, instruction
// classes, branch conditions, mux select codes and the control-word bundle.
package multicycle_pkg;

   localparam logic [3:0] S_FETCH      = 4'd0;
   localparam logic [3:0] S_DECODE     = 4'd1;
   localparam logic [3:0] S_EXEC_ALU   = 4'd2;
   localparam logic [3:0] S_EXEC_SHIFT = 4'd3;
   localparam logic [3:0] S_MEM_ADDR   = 4'd4;
   localparam logic [3:0] S_MEM_RD     = 4'd5;
   localparam logic [3:0] S_MEM_WR     = 4'd6;
   localparam logic [3:0] S_WB_ALU     = 4'd7;
   localparam logic [3:0] S_WB_MEM     = 4'd8;
   localparam logic [3:0] S_BRANCH     = 4'd9;
   localparam logic [3:0] S_BL_LINK    = 4'd10;

   localparam logic [1:0] CLS_DP    = 2'b00;
   localparam logic [1:0] CLS_SHIFT = 2'b01;
   localparam logic [1:0] CLS_MEM   = 2'b10;
   localparam logic [1:0] CLS_BR    = 2'b11;

   localparam logic [1:0] COND_AL = 2'b00;
   localparam logic [1:0] COND_EQ = 2'b01;
   localparam logic [1:0] COND_CS = 2'b10;
   localparam logic [1:0] COND_BL = 2'b11;

   localparam logic [1:0] BSRC_RD2 = 2'b00;
   localparam logic [1:0] BSRC_IMM = 2'b01;
   localparam logic [1:0] BSRC_ONE = 2'b10;

   localparam logic [1:0] REGSRC_ALU   = 2'b00;
   localparam logic [1:0] REGSRC_SHIFT = 2'b01;
   localparam logic [1:0] REGSRC_MEM   = 2'b10;
   localparam logic [1:0] REGSRC_PC    = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_MOV = 3'b111;

   typedef struct packed {
      logic       iregen;
      logic       pcen;
      logic       asrc0;
      logic       asrc1;
      logic [1:0] bsrc;
      logic       regwrite;
      logic [1:0] regsrc;
      logic       flgwrite;
      logic       idmwrite;
      logic       idmsrc;
      logic [2:0] aluctrl;
      logic [2:0] shiftctrl;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   function automatic logic [1:0] inst_class(input logic [15:0] inst);
      return inst[15:14];
   endfunction

endpackage

// File: rtl/mc_cond_check.sv
// Branch condition evaluation: always, on Z, on C, and BL (always).
module mc_cond_check
   import multicycle_pkg::*;
(
   input  logic [1:0] cond,
   input  logic       zeroflag,
   input  logic       carry,
   output logic       taken
);

   always_comb begin
      case (cond)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = zeroflag;
         COND_CS: taken = carry;
         default: taken = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle 16-bit CPU. Define MC_BL_EN to add the
// BL_LINK state; otherwise BL decodes as a two-cycle NOP.
module multicycle_ctrl
   import multicycle_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] Inst,
   input  logic        zeroflag,
   input  logic        carry,
   output logic [3:0]  state,
   output logic [3:0]  next_state,
   output logic        IRegen,
   output logic        pcEN,
   output logic        ASrc0,
   output logic        ASrc1,
   output logic [1:0]  BSrc,
   output logic        RegWrite,
   output logic [1:0]  RegSrc,
   output logic        FlgWrite,
   output logic        IDMWrite,
   output logic        IDMSrc,
   output logic [2:0]  ALUCtrl,
   output logic [2:0]  ShiftCtrl
);

   logic [1:0] cls;
   logic [1:0] cond;
   logic       taken;
   ctrl_t      c;
   logic       unused_inst;

   assign cls         = inst_class(Inst);
   assign cond        = Inst[13:12];
   assign unused_inst = ^Inst[8:0];

   mc_cond_check u_cond (
      .cond     (cond),
      .zeroflag (zeroflag),
      .carry    (carry),
      .taken    (taken)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:      next_state = S_DECODE;
         S_DECODE: begin
            case (cls)
               CLS_DP:    next_state = S_EXEC_ALU;
               CLS_SHIFT: next_state = S_EXEC_SHIFT;
               CLS_MEM:   next_state = S_MEM_ADDR;
               default: begin
`ifdef MC_BL_EN
                  next_state = (cond == COND_BL) ? S_BL_LINK : S_BRANCH;
`else
                  next_state = (cond == COND_BL) ? S_FETCH : S_BRANCH;
`endif
               end
            endcase
         end
         S_EXEC_ALU:   next_state = S_WB_ALU;
         S_EXEC_SHIFT: next_state = S_WB_ALU;
         S_MEM_ADDR:   next_state = Inst[13] ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:     next_state = S_WB_MEM;
`ifdef MC_BL_EN
         S_BL_LINK:    next_state = S_BRANCH;
`endif
         default:      next_state = S_FETCH;
      endcase
   end

   // Outputs depend on state and Inst only; flags reach pcEN solely in BRANCH.
   always_comb begin
      c = CTRL_IDLE;
      case (state)
         S_FETCH: begin
            c.iregen  = 1'b1;
            c.pcen    = 1'b1;
            c.asrc0   = 1'b1;
            c.bsrc    = BSRC_ONE;
            c.aluctrl = ALU_ADD;
         end
         S_EXEC_ALU: begin
            c.aluctrl  = Inst[13:11];
            c.bsrc     = {1'b0, Inst[10]};
            c.asrc1    = (Inst[13:11] == ALU_MOV);
            c.flgwrite = Inst[9];
         end
         S_EXEC_SHIFT: begin
            c.shiftctrl = Inst[13:11];
            c.flgwrite  = Inst[9];
            c.regsrc    = REGSRC_SHIFT;
         end
         S_WB_ALU: begin
            c.regwrite = 1'b1;
            c.regsrc   = (cls == CLS_SHIFT) ? REGSRC_SHIFT : REGSRC_ALU;
         end
         S_MEM_ADDR: begin
            c.aluctrl = ALU_ADD;
            c.bsrc    = BSRC_IMM;
         end
         S_MEM_RD: c.idmsrc = 1'b1;
         S_MEM_WR: begin
            c.idmsrc   = 1'b1;
            c.idmwrite = 1'b1;
         end
         S_WB_MEM: begin
            c.regwrite = 1'b1;
            c.regsrc   = REGSRC_MEM;
         end
         S_BRANCH: begin
            c.asrc0   = 1'b1;
            c.bsrc    = BSRC_IMM;
            c.aluctrl = ALU_ADD;
            c.pcen    = taken;
         end
`ifdef MC_BL_EN
         S_BL_LINK: begin
            c.regwrite = 1'b1;
            c.regsrc   = REGSRC_PC;
         end
`endif
         default: c = CTRL_IDLE;
      endcase
   end

   // Write strobes are killed during reset; selects keep their FETCH values.
   assign IRegen    = c.iregen   & ~reset;
   assign pcEN      = c.pcen     & ~reset;
   assign RegWrite  = c.regwrite & ~reset;
   assign FlgWrite  = c.flgwrite & ~reset;
   assign IDMWrite  = c.idmwrite & ~reset;
   assign ASrc0     = c.asrc0;
   assign ASrc1     = c.asrc1;
   assign BSrc      = c.bsrc;
   assign RegSrc    = c.regsrc;
   assign IDMSrc    = c.idmsrc;
   assign ALUCtrl   = c.aluctrl;
   assign ShiftCtrl = c.shiftctrl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from
// the instruction rules, random instruction stream, plus pinned literal traces.
module tb_multicycle_ctrl;

   logic        clock;
   logic        reset;
   logic [15:0] Inst;
   logic        zeroflag;
   logic        carry;
   logic [3:0]  state;
   logic [3:0]  next_state;
   logic        IRegen, pcEN, ASrc0, ASrc1, RegWrite, FlgWrite, IDMWrite, IDMSrc;
   logic [1:0]  BSrc, RegSrc;
   logic [2:0]  ALUCtrl, ShiftCtrl;

   multicycle_ctrl dut (
      .clock(clock), .reset(reset), .Inst(Inst), .zeroflag(zeroflag), .carry(carry),
      .state(state), .next_state(next_state), .IRegen(IRegen), .pcEN(pcEN),
      .ASrc0(ASrc0), .ASrc1(ASrc1), .BSrc(BSrc), .RegWrite(RegWrite), .RegSrc(RegSrc),
      .FlgWrite(FlgWrite), .IDMWrite(IDMWrite), .IDMSrc(IDMSrc), .ALUCtrl(ALUCtrl),
      .ShiftCtrl(ShiftCtrl)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // pcm: 0 = pcEN low, 1 = pcEN high, 2 = follows zeroflag, 3 = follows carry
   typedef struct {
      logic [3:0] st;
      logic       iregen;
      int         pcm;
      logic       asrc0, asrc1;
      logic [1:0] bsrc;
      logic       rw;
      logic [1:0] rsrc;
      logic       fw, mw, msrc;
      logic [2:0] alu, sh;
   } rec_t;

   rec_t        exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [15:0] cur_inst;
   logic [31:0] tr, rw_m, fw_m, pc_m, ms_m, mw_m, rs_m;
   int          cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s inst=%h t=%0t: got %0h expected %0h", nm, cur_inst, $time, act, expv);
      end
   endtask

   function automatic rec_t blank(input logic [3:0] s);
      rec_t r;
      r.st = s; r.iregen = 1'b0; r.pcm = 0; r.asrc0 = 1'b0; r.asrc1 = 1'b0;
      r.bsrc = 2'b00; r.rw = 1'b0; r.rsrc = 2'b00; r.fw = 1'b0; r.mw = 1'b0;
      r.msrc = 1'b0; r.alu = 3'b000; r.sh = 3'b000;
      return r;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction, from FETCH to its last state.
   function automatic void build(input logic [15:0] ins);
      rec_t r;
      logic [1:0] cond;
      exp_q.delete();
      r = blank(4'd0); r.iregen = 1'b1; r.pcm = 1; r.asrc0 = 1'b1; r.bsrc = 2'b10;
      exp_q.push_back(r);
      exp_q.push_back(blank(4'd1));
      cond = ins[13:12];
      case (ins[15:14])
         2'b00: begin
            r = blank(4'd2); r.alu = ins[13:11]; r.bsrc = {1'b0, ins[10]};
            r.asrc1 = (ins[13:11] == 3'b111); r.fw = ins[9];
            exp_q.push_back(r);
            r = blank(4'd7); r.rw = 1'b1; exp_q.push_back(r);
         end
         2'b01: begin
            r = blank(4'd3); r.sh = ins[13:11]; r.fw = ins[9]; r.rsrc = 2'b01;
            exp_q.push_back(r);
            r = blank(4'd7); r.rw = 1'b1; r.rsrc = 2'b01; exp_q.push_back(r);
         end
         2'b10: begin
            r = blank(4'd4); r.bsrc = 2'b01; exp_q.push_back(r);
            if (ins[13]) begin
               r = blank(4'd5); r.msrc = 1'b1; exp_q.push_back(r);
               r = blank(4'd8); r.rw = 1'b1; r.rsrc = 2'b10; exp_q.push_back(r);
            end else begin
               r = blank(4'd6); r.msrc = 1'b1; r.mw = 1'b1; exp_q.push_back(r);
            end
         end
         default: begin
`ifdef MC_BL_EN
            if (cond == 2'b11) begin
               r = blank(4'd10); r.rw = 1'b1; r.rsrc = 2'b11; exp_q.push_back(r);
            end
            r = blank(4'd9); r.asrc0 = 1'b1; r.bsrc = 2'b01;
            r.pcm = (cond == 2'b01) ? 2 : (cond == 2'b10) ? 3 : 1;
            exp_q.push_back(r);
`else
            if (cond != 2'b11) begin
               r = blank(4'd9); r.asrc0 = 1'b1; r.bsrc = 2'b01;
               r.pcm = (cond == 2'b01) ? 2 : (cond == 2'b10) ? 3 : 1;
               exp_q.push_back(r);
            end
`endif
         end
      endcase
   endfunction

   // fm: 0 = random flags each cycle, 1 = flags forced 0, 2 = flags forced 1
   task automatic run_inst(input logic [15:0] ins, input int fm);
      rec_t       r;
      logic [3:0] nxt;
      logic       pe;
      cur_inst = ins;
      build(ins);
      tr = 0; rw_m = 0; fw_m = 0; pc_m = 0; ms_m = 0; mw_m = 0; rs_m = 0; cnt = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         r = exp_q[i];
         case (fm)
            1:       begin zeroflag = 1'b0; carry = 1'b0; end
            2:       begin zeroflag = 1'b1; carry = 1'b1; end
            default: begin zeroflag = 1'($urandom_range(0, 1)); carry = 1'($urandom_range(0, 1)); end
         endcase
         if (i == 0) Inst = ins;
         #1;
         nxt = (i + 1 < exp_q.size()) ? exp_q[i + 1].st : 4'd0;
         case (r.pcm)
            0:       pe = 1'b0;
            1:       pe = 1'b1;
            2:       pe = zeroflag;
            default: pe = carry;
         endcase
         chk("state",      32'(state),      32'(r.st));
         chk("next_state", 32'(next_state), 32'(nxt));
         chk("IRegen",     32'(IRegen),     32'(r.iregen));
         chk("pcEN",       32'(pcEN),       32'(pe));
         chk("ASrc0",      32'(ASrc0),      32'(r.asrc0));
         chk("ASrc1",      32'(ASrc1),      32'(r.asrc1));
         chk("BSrc",       32'(BSrc),       32'(r.bsrc));
         chk("RegWrite",   32'(RegWrite),   32'(r.rw));
         chk("RegSrc",     32'(RegSrc),     32'(r.rsrc));
         chk("FlgWrite",   32'(FlgWrite),   32'(r.fw));
         chk("IDMWrite",   32'(IDMWrite),   32'(r.mw));
         chk("IDMSrc",     32'(IDMSrc),     32'(r.msrc));
         chk("ALUCtrl",    32'(ALUCtrl),    32'(r.alu));
         chk("ShiftCtrl",  32'(ShiftCtrl),  32'(r.sh));
         chk("write_excl", 32'(RegWrite & IDMWrite), 32'd0);
         tr   = {tr[27:0], state};
         rw_m = {rw_m[30:0], RegWrite};
         fw_m = {fw_m[30:0], FlgWrite};
         pc_m = {pc_m[30:0], pcEN};
         ms_m = {ms_m[30:0], IDMSrc};
         mw_m = {mw_m[30:0], IDMWrite};
         rs_m = {rs_m[29:0], RegSrc};
         cnt++;
         @(negedge clock);
      end
   endtask

   task automatic reset_mid();
      cur_inst = 16'hA005;
      Inst = 16'hA005;
      for (int i = 0; i < 3; i++) begin
         zeroflag = 1'($urandom_range(0, 1)); carry = 1'($urandom_range(0, 1));
         #1;
         chk("rst_pre_state", 32'(state), (i == 0) ? 32'd0 : (i == 1) ? 32'd1 : 32'd4);
         @(negedge clock);
      end
      #1;
      chk("rst_in_memrd", 32'(state), 32'd5);
      #2 reset = 1'b1;
      #1;
      chk("rst_state",    32'(state),    32'd0);
      chk("rst_IRegen",   32'(IRegen),   32'd0);
      chk("rst_pcEN",     32'(pcEN),     32'd0);
      chk("rst_RegWrite", 32'(RegWrite), 32'd0);
      chk("rst_FlgWrite", 32'(FlgWrite), 32'd0);
      chk("rst_IDMWrite", 32'(IDMWrite), 32'd0);
      chk("rst_IDMSrc",   32'(IDMSrc),   32'd0);
      chk("rst_ASrc0",    32'(ASrc0),    32'd1);
      chk("rst_BSrc",     32'(BSrc),     32'd2);
      @(negedge clock);
      chk("rst_held", 32'(state), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      logic [15:0] rnd;
      reset = 1'b1; Inst = 16'h0000; zeroflag = 1'b0; carry = 1'b0; cur_inst = 16'h0000;
      #1;
      chk("init_state",    32'(state),      32'd0);
      chk("init_next",     32'(next_state), 32'd1);
      chk("init_IRegen",   32'(IRegen),     32'd0);
      chk("init_pcEN",     32'(pcEN),       32'd0);
      chk("init_RegWrite", 32'(RegWrite),   32'd0);
      chk("init_ASrc0",    32'(ASrc0),      32'd1);
      chk("init_BSrc",     32'(BSrc),       32'd2);
      @(negedge clock); @(negedge clock);
      reset = 1'b0;

      run_inst(16'h0200, 0);
      chk("add_trace", tr, 32'h0127);
      chk("add_len",   32'(cnt), 32'd4);
      chk("add_rw",    rw_m, 32'b0001);
      chk("add_fw",    fw_m, 32'b0010);

      run_inst(16'hA005, 0);
      chk("ld_trace", tr, 32'h01458);
      chk("ld_len",   32'(cnt), 32'd5);
      chk("ld_msrc",  ms_m, 32'b00010);
      chk("ld_rw",    rw_m, 32'b00001);
      chk("ld_rsrc",  rs_m, 32'h2);

      run_inst(16'h8005, 0);
      chk("st_trace", tr, 32'h0146);
      chk("st_mw",    mw_m, 32'b0001);
      chk("st_rw",    rw_m, 32'b0000);

      run_inst(16'hD004, 1);
      chk("beq_trace", tr, 32'h019);
      chk("beq_nt_pc", pc_m, 32'b100);
      run_inst(16'hD004, 2);
      chk("beq_t_pc",  pc_m, 32'b101);

      run_inst(16'hF010, 0);
`ifdef MC_BL_EN
      chk("bl_trace", tr, 32'h01A9);
      chk("bl_len",   32'(cnt), 32'd4);
      chk("bl_rsrc",  rs_m, 32'h0C);
`else
      chk("bl_trace", tr, 32'h01);
      chk("bl_len",   32'(cnt), 32'd2);
      chk("bl_rw",    rw_m, 32'd0);
`endif

      reset_mid();
      run_inst(16'h0200, 0);
      chk("post_rst_trace", tr, 32'h0127);

      for (int k = 0; k < 300; k++) begin
         rnd = 16'($urandom);
         run_inst(rnd, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
